// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: walks the enabled analog mux channels, settles, kicks the SAR,
// waits for its ready edge (with timeout) and strobes one result per channel.
// Optional build macro ADC_SCAN_AVG_EN: four conversions per channel, averaged.
module adc_scan_ctrl #(
    parameter int unsigned RESOLUTION     = 8,
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned SETTLE_CYCLES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      enable_i,
    input  logic                      trig_i,
    input  logic                      continuous_i,
    input  logic [NUM_CH-1:0]         ch_mask_i,
    output logic [$clog2(NUM_CH)-1:0] ch_sel_o,
    output logic                      sar_start_o,
    input  logic                      sar_rdy_i,
    input  logic [RESOLUTION-1:0]     sar_result_i,
    output logic                      data_valid_o,
    output logic [$clog2(NUM_CH)-1:0] data_ch_o,
    output logic [RESOLUTION-1:0]     data_o,
    output logic                      busy_o,
    output logic                      scan_done_o,
    output logic                      err_o
);

    localparam int unsigned CW           = $clog2(NUM_CH);
    localparam int unsigned SW           = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned SETTLE_LAST  = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
    localparam int unsigned TW           = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned TIMEOUT_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_START,
        ST_WAIT,
        ST_STORE
    } state_e;

    // A channel begins in SETTLE unless no settling time is configured.
    localparam state_e CH_ENTRY = (SETTLE_CYCLES == 0) ? ST_START : ST_SETTLE;

    state_e            state_q, state_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [CW-1:0]     ch_sel_q, ch_sel_d;
    logic [SW-1:0]     settle_cnt_q, settle_cnt_d;
    logic [TW-1:0]     wait_cnt_q, wait_cnt_d;
    logic              rdy_q, rdy_d;
    logic              sar_start_q, sar_start_d;
    logic              data_valid_q, data_valid_d;
    logic [CW-1:0]     data_ch_q, data_ch_d;
    logic [RESOLUTION-1:0] data_q, data_d;
    logic              busy_q, busy_d;
    logic              scan_done_q, scan_done_d;
    logic              err_q, err_d;

    logic              rdy_rise;
    logic [CW:0]       nxt;
    logic              has_next;
    logic [CW-1:0]     nxt_idx;

`ifdef ADC_SCAN_AVG_EN
    localparam int unsigned AW = RESOLUTION + 2;
    logic [AW-1:0]     acc_q, acc_d;
    logic [1:0]        avg_cnt_q, avg_cnt_d;
    logic [AW-1:0]     acc_sum;
`endif

    // Lowest set bit of a channel mask (0 when the mask is empty).
    function automatic logic [CW-1:0] lowest_bit(input logic [NUM_CH-1:0] m);
        logic [CW-1:0] r;
        r = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (m[i]) r = CW'(i);
        end
        return r;
    endfunction

    // Next set bit strictly above cur, MSB of the result flags that one exists.
    function automatic logic [CW:0] next_above(input logic [NUM_CH-1:0] m,
                                               input logic [CW-1:0]     cur);
        logic [CW:0] r;
        r = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (m[i] && (i > int'(cur))) r = {1'b1, CW'(i)};
        end
        return r;
    endfunction

    // Next-state and registered-output decode.
    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        ch_sel_d     = ch_sel_q;
        settle_cnt_d = settle_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        rdy_d        = sar_rdy_i;
        sar_start_d  = 1'b0;
        data_valid_d = 1'b0;
        data_ch_d    = data_ch_q;
        data_d       = data_q;
        busy_d       = busy_q;
        scan_done_d  = 1'b0;
        err_d        = err_q;
`ifdef ADC_SCAN_AVG_EN
        acc_d        = acc_q;
        avg_cnt_d    = avg_cnt_q;
        acc_sum      = acc_q + AW'(sar_result_i);
`endif

        rdy_rise = sar_rdy_i && !rdy_q;
        nxt      = next_above(mask_q, ch_sel_q);
        has_next = nxt[CW];
        nxt_idx  = nxt[CW-1:0];

        if (!enable_i) begin
            state_d      = ST_IDLE;
            settle_cnt_d = '0;
            wait_cnt_d   = '0;
`ifdef ADC_SCAN_AVG_EN
            acc_d        = '0;
            avg_cnt_d    = '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
`ifdef ADC_SCAN_AVG_EN
                    acc_d     = '0;
                    avg_cnt_d = '0;
`endif
                    if (trig_i && (ch_mask_i != '0)) begin
                        mask_d       = ch_mask_i;
                        ch_sel_d     = lowest_bit(ch_mask_i);
                        err_d        = 1'b0;
                        settle_cnt_d = '0;
                        state_d      = CH_ENTRY;
                    end
                end

                ST_SETTLE: begin
                    if (settle_cnt_q == SW'(SETTLE_LAST)) begin
                        settle_cnt_d = '0;
                        state_d      = ST_START;
                    end else begin
                        settle_cnt_d = settle_cnt_q + SW'(1);
                    end
                end

                ST_START: begin
                    sar_start_d = 1'b1;
                    wait_cnt_d  = '0;
                    state_d     = ST_WAIT;
                end

                ST_WAIT: begin
                    if (rdy_rise) begin
`ifdef ADC_SCAN_AVG_EN
                        if (avg_cnt_q == 2'd3) begin
                            data_d       = RESOLUTION'(acc_sum >> 2);
                            data_ch_d    = ch_sel_q;
                            data_valid_d = 1'b1;
                            scan_done_d  = !has_next;
                            acc_d        = '0;
                            avg_cnt_d    = '0;
                            state_d      = ST_STORE;
                        end else begin
                            acc_d        = acc_sum;
                            avg_cnt_d    = avg_cnt_q + 2'd1;
                            settle_cnt_d = '0;
                            state_d      = CH_ENTRY;
                        end
`else
                        data_d       = sar_result_i;
                        data_ch_d    = ch_sel_q;
                        data_valid_d = 1'b1;
                        scan_done_d  = !has_next;
                        state_d      = ST_STORE;
`endif
                    end else if (wait_cnt_q == TW'(TIMEOUT_LAST)) begin
                        // Timed-out channel still passes through STORE, just without a strobe.
                        err_d       = 1'b1;
                        scan_done_d = !has_next;
                        state_d     = ST_STORE;
`ifdef ADC_SCAN_AVG_EN
                        acc_d       = '0;
                        avg_cnt_d   = '0;
`endif
                    end else begin
                        wait_cnt_d = wait_cnt_q + TW'(1);
                    end
                end

                ST_STORE: begin
                    settle_cnt_d = '0;
                    if (has_next) begin
                        ch_sel_d = nxt_idx;
                        state_d  = CH_ENTRY;
                    end else if (continuous_i && (ch_mask_i != '0)) begin
                        mask_d   = ch_mask_i;
                        ch_sel_d = lowest_bit(ch_mask_i);
                        state_d  = CH_ENTRY;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end

                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            mask_q       <= '0;
            ch_sel_q     <= '0;
            settle_cnt_q <= '0;
            wait_cnt_q   <= '0;
            rdy_q        <= 1'b0;
            sar_start_q  <= 1'b0;
            data_valid_q <= 1'b0;
            data_ch_q    <= '0;
            data_q       <= '0;
            busy_q       <= 1'b0;
            scan_done_q  <= 1'b0;
            err_q        <= 1'b0;
`ifdef ADC_SCAN_AVG_EN
            acc_q        <= '0;
            avg_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            ch_sel_q     <= ch_sel_d;
            settle_cnt_q <= settle_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            rdy_q        <= rdy_d;
            sar_start_q  <= sar_start_d;
            data_valid_q <= data_valid_d;
            data_ch_q    <= data_ch_d;
            data_q       <= data_d;
            busy_q       <= busy_d;
            scan_done_q  <= scan_done_d;
            err_q        <= err_d;
`ifdef ADC_SCAN_AVG_EN
            acc_q        <= acc_d;
            avg_cnt_q    <= avg_cnt_d;
`endif
        end
    end

    assign ch_sel_o     = ch_sel_q;
    assign sar_start_o  = sar_start_q;
    assign data_valid_o = data_valid_q;
    assign data_ch_o    = data_ch_q;
    assign data_o       = data_q;
    assign busy_o       = busy_q;
    assign scan_done_o  = scan_done_q;
    assign err_o        = err_q;

endmodule

// File: doc/adc_scan_ctrl.md
ADC_SCAN_CTRL -- requirements
Module: adc_scan_ctrl

Interface
REQ-001 SHALL have parameter RESOLUTION, default 8, SAR result width in bits.
REQ-002 SHALL have parameter NUM_CH, default 4, number of analog mux channels (2..16).
REQ-003 SHALL have parameter SETTLE_CYCLES, default 2, mux settling cycles before each start (0 allowed).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 64, maximum wait for SAR ready after start.
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk_i  in  1  clock; rst_i  in  1  synchronous active-high reset.
REQ-006 SHALL have port enable_i  in  1  controller enable; low forces IDLE.
REQ-007 SHALL have port trig_i  in  1  start one scan (level, sampled in IDLE).
REQ-008 SHALL have port continuous_i  in  1  restart the scan automatically after completion.
REQ-009 SHALL have port ch_mask_i  in  NUM_CH  channels included in the scan.
REQ-010 SHALL have port ch_sel_o  out  $clog2(NUM_CH)  analog mux select.
REQ-011 SHALL have port sar_start_o  out  1  SAR start pulse.
REQ-012 SHALL have port sar_rdy_i  in  1  SAR ready level.
REQ-013 SHALL have port sar_result_i  in  RESOLUTION  SAR result.
REQ-014 SHALL have ports data_valid_o  out  1; data_ch_o  out  $clog2(NUM_CH); data_o  out  RESOLUTION: per-channel result strobe, channel, value.
REQ-015 SHALL have ports busy_o  out  1; scan_done_o  out  1 (1-cycle pulse); err_o  out  1 (sticky timeout flag).

Function
REQ-016 SHALL implement states IDLE, SETTLE, START, WAIT, STORE.
REQ-017 SHALL, in IDLE with enable_i=1, trig_i=1 and ch_mask_i!=0, latch ch_mask_i and, next cycle, drive ch_sel_o to the lowest set bit and enter SETTLE.
REQ-018 SHALL ignore trig_i when ch_mask_i==0 and whenever the state is not IDLE.
REQ-019 SHALL remain in SETTLE exactly SETTLE_CYCLES cycles; SETTLE_CYCLES=0 enters START directly.
REQ-020 SHALL assert sar_start_o for exactly one cycle (START), then enter WAIT.
REQ-021 SHALL register sar_rdy_i each cycle and, in WAIT, detect a rising edge (current 1, previous 0); on that cycle capture sar_result_i and enter STORE.
REQ-022 SHALL, in STORE, pulse data_valid_o for one cycle with data_o and data_ch_o equal to the captured result and channel.
REQ-023 SHALL, after STORE, advance to the next higher set bit of the latched mask (SETTLE) or, if none remain, pulse scan_done_o in that same STORE cycle.
REQ-024 SHALL, at scan end, restart from the lowest set bit of a freshly sampled ch_mask_i if continuous_i=1 and ch_mask_i!=0, else return to IDLE.
REQ-025 SHALL count WAIT cycles; on reaching TIMEOUT_CYCLES without a rising edge set err_o, produce no data_valid_o for that channel, and advance as in REQ-023.
REQ-026 SHALL keep err_o set until reset or a new trig_i accepted in IDLE.
REQ-027 SHALL, when enable_i=0 in any state, enter IDLE next cycle, deassert sar_start_o, and emit no further data_valid_o or scan_done_o.
REQ-028 SHALL drive busy_o high in every state except IDLE.
REQ-029 SHALL hold ch_sel_o constant from entry to SETTLE through STORE of each channel.

Reset
REQ-030 SHALL, on rst_i=1 at a clock edge, set state IDLE, ch_sel_o=0, sar_start_o=0, data_valid_o=0, data_ch_o=0, data_o=0, busy_o=0, scan_done_o=0, err_o=0, counters and latched mask=0.
REQ-031 SHALL apply reset mid-scan identically, discarding any conversion in flight.

Configuration
REQ-032 SHALL support macro ADC_SCAN_AVG_EN: when defined, each channel performs 4 consecutive START/WAIT conversions (each with its own SETTLE), sums them in a RESOLUTION+2-bit accumulator, and reports sum>>2 (truncating) in a single STORE.
REQ-033 SHALL, without ADC_SCAN_AVG_EN, perform exactly one conversion per channel and contain no accumulator.
REQ-034 SHALL, with ADC_SCAN_AVG_EN, treat a timeout on any of the 4 conversions as a timeout for the whole channel (REQ-025).

Verification
REQ-035 SHALL cover: mask=4'b1011, trig pulse, SAR model returning 0x10*(ch+1) -> data_valid_o for ch 0,1,3 with 0x10,0x20,0x40, then one scan_done_o, return to IDLE.
REQ-036 SHALL cover: SETTLE_CYCLES=2 -> sar_start_o asserted exactly 3 cycles after ch_sel_o changes, one cycle wide.
REQ-037 SHALL cover: SAR model never raising ready on ch 1, mask=4'b0011 -> err_o set after 64 WAIT cycles, data only for ch 0, scan_done_o still pulses.
REQ-038 SHALL cover: continuous_i=1, mask=4'b0001, 3 scans -> 3 data_valid_o and 3 scan_done_o; then enable_i=0 mid-WAIT -> IDLE next cycle, no further strobes.
REQ-039 SHALL cover: rst_i asserted in WAIT -> all outputs at reset values next cycle; trig_i with mask=0 -> busy_o stays 0.
REQ-040 SHALL cover (ADC_SCAN_AVG_EN): results 10,11,12,14 on ch 2 -> data_o=11, exactly 4 sar_start_o pulses per channel.
